// File: rtl/inert_intf_pkg.sv
// Shared definitions for the inertial-sensor SPI front end.
//   state_t      : controller states (also exported on the debug port)
//   INIT_TMR_W   : power-up wait timer width
//   SPI_RD       : R/W bit value that marks an SPI read
//   init_word()  : the four configuration words written after power-up
// Build option: define FAST_SIM_EN to shrink the power-up wait to 512
// cycles (9-bit timer); without it the wait is 65536 cycles (16-bit timer).
package inert_intf_pkg;

    typedef enum logic [2:0] {
        INIT_WAIT = 3'd0,
        INIT_WR   = 3'd1,
        WAIT_INT  = 3'd2,
        READ      = 3'd3,
        SHOW      = 3'd4
    } state_t;

`ifdef FAST_SIM_EN
    localparam int INIT_TMR_W = 9;
`else
    localparam int INIT_TMR_W = 16;
`endif

    localparam logic SPI_RD = 1'b1;

    localparam logic [15:0] INIT_WORD0 = 16'h0D02;
    localparam logic [15:0] INIT_WORD1 = 16'h1053;
    localparam logic [15:0] INIT_WORD2 = 16'h1150;
    localparam logic [15:0] INIT_WORD3 = 16'h1460;

    function automatic logic [15:0] init_word(input logic [1:0] idx);
        logic [15:0] w;
        case (idx)
            2'd0:    w = INIT_WORD0;
            2'd1:    w = INIT_WORD1;
            2'd2:    w = INIT_WORD2;
            default: w = INIT_WORD3;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/inert_intf_if.sv
// SPI request/response bundle between the sensor front end and the SPI
// monarch.
//   wrt        : one-cycle request, asserted only when no transaction is open
//   cmd        : {R/W, addr[6:0], data[7:0]}, stable from wrt until done
//   done       : one-cycle completion of the open transaction
//   inert_data : read word returned by the sensor; only [7:0] carries data
// Handshake: a transaction opens on the wrt cycle and closes on the cycle
// done is high; done outside an open transaction carries no meaning.
interface inert_intf_if;
    logic        wrt;
    logic [15:0] cmd;
    logic        done;
    logic [15:0] inert_data;

    modport master (output wrt, output cmd, input done, input inert_data);
    modport slave  (input wrt, input cmd, output done, output inert_data);
endinterface

// File: rtl/inert_intf_int_sync.sv
// Two-flop synchronizer for the sensor data-ready line.
//   clk, rst_n : clock and asynchronous active-low reset
//   async_i    : asynchronous input
//   sync_o     : second-stage flop output (the only safe tap)
module int_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic sync_o
);
    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;
endmodule

// File: rtl/inert_intf.sv
// Inertial-sensor front end: after a power-up wait it writes four
// configuration words over SPI, then on every data-ready interrupt reads
// pitch-rate and Z-accel (low/high bytes) and presents them with a
// one-cycle vld pulse.
//   clk, rst_n : clock, asynchronous active-low reset
//   INT        : sensor data-ready (asynchronous)
//   spi        : SPI request bundle (master side)
//   ptch_rt    : signed pitch rate, updated only in the vld cycle
//   AZ         : signed Z acceleration, updated only in the vld cycle
//   vld        : one-cycle pulse marking a new ptch_rt/AZ pair
//   state_o    : current controller state (debug)
// Build option: FAST_SIM_EN shortens the power-up wait (see package).
module inert_intf
    import inert_intf_pkg::*;
#(
    parameter logic [6:0] PTCH_ADDR = 7'h22,
    parameter logic [6:0] AZ_ADDR   = 7'h2C
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            INT,
    inert_intf_if.master    spi,
    output logic [15:0]     ptch_rt,
    output logic [15:0]     AZ,
    output logic            vld,
    output state_t          state_o
);

    logic                  int_s;
    state_t                state_q, state_d;
    logic [1:0]            idx_q, idx_d;
    logic [INIT_TMR_W-1:0] tmr_q, tmr_d;
    logic                  launch;
    logic                  wrt_q, wrt_d;
    logic [15:0]           cmd_q, cmd_d;
    logic [7:0]            hold_q [4];
    logic                  cap_en;
    logic                  show_ld;
    logic [15:0]           ptch_q, ptch_d;
    logic [15:0]           az_q, az_d;
    logic [7:0]            rd_byte;
    logic                  unused_rd_hi;

    int_sync u_int_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (INT),
        .sync_o  (int_s)
    );

    assign rd_byte      = spi.inert_data[7:0];
    assign unused_rd_hi = ^spi.inert_data[15:8];

    function automatic logic [15:0] read_word(input logic [1:0] idx);
        logic [15:0] w;
        case (idx)
            2'd0:    w = {SPI_RD, PTCH_ADDR,         8'h00};
            2'd1:    w = {SPI_RD, PTCH_ADDR + 7'd1,  8'h00};
            2'd2:    w = {SPI_RD, AZ_ADDR,           8'h00};
            default: w = {SPI_RD, AZ_ADDR + 7'd1,    8'h00};
        endcase
        return w;
    endfunction

    // State register (timer and transaction index travel with the state)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT_WAIT;
            idx_q   <= 2'd0;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tmr_q   <= tmr_d;
        end
    end

    // Next-state logic. 'launch' marks entry into a new transaction; it is
    // only raised on done (or from idle/timer), so a request can never
    // overlap an open transaction.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tmr_d   = tmr_q;
        launch  = 1'b0;
        case (state_q)
            INIT_WAIT: begin
                tmr_d = tmr_q + 1'b1;
                if (&tmr_q) begin
                    state_d = INIT_WR;
                    idx_d   = 2'd0;
                    launch  = 1'b1;
                end
            end
            INIT_WR: begin
                if (spi.done) begin
                    if (idx_q == 2'd3) begin
                        state_d = WAIT_INT;
                    end else begin
                        idx_d  = idx_q + 2'd1;
                        launch = 1'b1;
                    end
                end
            end
            WAIT_INT: begin
                if (int_s) begin
                    state_d = READ;
                    idx_d   = 2'd0;
                    launch  = 1'b1;
                end
            end
            READ: begin
                if (spi.done) begin
                    if (idx_q == 2'd3) begin
                        state_d = SHOW;
                    end else begin
                        idx_d  = idx_q + 2'd1;
                        launch = 1'b1;
                    end
                end
            end
            SHOW: begin
                state_d = WAIT_INT;
            end
            default: begin
                state_d = INIT_WAIT;
            end
        endcase
    end

    // Output logic. The final high byte bypasses its holding register so the
    // result registers load on the same edge that enters SHOW, making the
    // new values visible exactly in the vld cycle.
    always_comb begin
        wrt_d = launch;
        cmd_d = cmd_q;
        if (launch) begin
            cmd_d = (state_d == READ) ? read_word(idx_d) : init_word(idx_d);
        end
        cap_en  = (state_q == READ) && spi.done;
        show_ld = cap_en && (idx_q == 2'd3);
        ptch_d  = show_ld ? {hold_q[1], hold_q[0]} : ptch_q;
        az_d    = show_ld ? {rd_byte, hold_q[2]}   : az_q;
        vld     = (state_q == SHOW);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrt_q  <= 1'b0;
            cmd_q  <= 16'h0000;
            ptch_q <= 16'h0000;
            az_q   <= 16'h0000;
            for (int i = 0; i < 4; i++) begin
                hold_q[i] <= 8'h00;
            end
        end else begin
            wrt_q  <= wrt_d;
            cmd_q  <= cmd_d;
            ptch_q <= ptch_d;
            az_q   <= az_d;
            if (cap_en) begin
                hold_q[idx_q] <= rd_byte;
            end
        end
    end

    assign spi.wrt = wrt_q;
    assign spi.cmd = cmd_q;
    assign ptch_rt = ptch_q;
    assign AZ      = az_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_inert_intf.sv
// Bench for inert_intf: SPI responder with fixed 40-cycle latency, a
// transaction-level reference model compared every cycle, and directed
// scenarios (init sequence, reads, INT noise, spurious done, reset).
module tb_inert_intf;
    import inert_intf_pkg::*;

`ifdef FAST_SIM_EN
    localparam int INIT_CYC = 512;
`else
    localparam int INIT_CYC = 65536;
`endif
    localparam int SPI_LAT = 40;

    // ---------------- clock / reset / DUT ----------------
    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        INT   = 1'b0;
    logic [15:0] ptch_rt;
    logic [15:0] AZ;
    logic        vld;
    state_t      state_o;

    inert_intf_if spi_if ();

    inert_intf dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .INT     (INT),
        .spi     (spi_if),
        .ptch_rt (ptch_rt),
        .AZ      (AZ),
        .vld     (vld),
        .state_o (state_o)
    );

    always #5 clk = ~clk;

    int checks  = 0;
    int errors  = 0;
    int vld_seen = 0;

    logic [15:0] rlog [$];
    logic [7:0]  resp_byte [4];
    bit          spur_req = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] resp_for(input logic [15:0] c);
        logic [7:0] b;
        case (c[14:8])
            7'h22:   b = resp_byte[0];
            7'h23:   b = resp_byte[1];
            7'h2C:   b = resp_byte[2];
            7'h2D:   b = resp_byte[3];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // ---------------- SPI responder ----------------
    initial begin : responder
        int          cnt;
        bit          busy;
        logic [15:0] cur;
        cnt = 0;
        busy = 1'b0;
        cur = 16'h0;
        spi_if.done       = 1'b0;
        spi_if.inert_data = 16'h0;
        forever begin
            @(posedge clk);
            #1;
            spi_if.done = 1'b0;
            if (!rst_n) begin
                busy = 1'b0;
            end else begin
                if (busy) begin
                    cnt++;
                    if (cnt == SPI_LAT) begin
                        busy = 1'b0;
                        spi_if.done = 1'b1;
                        spi_if.inert_data = {8'($urandom_range(0, 255)), resp_for(cur)};
                    end
                end else if (spur_req) begin
                    spur_req = 1'b0;
                    spi_if.done = 1'b1;
                    spi_if.inert_data = 16'h5AC3;
                end
                if (spi_if.wrt) begin
                    rlog.push_back(spi_if.cmd);
                    cur  = spi_if.cmd;
                    busy = 1'b1;
                    cnt  = 0;
                end
            end
        end
    end

    // ---------------- reference model + per-cycle compare ----------------
    initial begin : model
        int          cd;
        bit          in_wait, outstanding, issue_next, vld_next, idle, prev_int;
        logic [15:0] pend [$];
        logic [15:0] e_cmd, e_ptch, e_az;
        logic        e_wrt, e_vld;
        logic [7:0]  bmap [128];
        cd = INIT_CYC; in_wait = 1; outstanding = 0; issue_next = 0; vld_next = 0;
        prev_int = 0; e_cmd = 0; e_ptch = 0; e_az = 0; e_wrt = 0; e_vld = 0;
        for (int i = 0; i < 128; i++) bmap[i] = 8'h00;
        forever begin
            @(posedge clk);
            #2;
            e_wrt = 1'b0;
            e_vld = 1'b0;
            if (!rst_n) begin
                cd = INIT_CYC; in_wait = 1; outstanding = 0; issue_next = 0;
                vld_next = 0; prev_int = 0; pend.delete();
                e_cmd = 16'h0; e_ptch = 16'h0; e_az = 16'h0;
            end else begin
                if (in_wait) begin
                    cd--;
                    if (cd == 0) begin
                        in_wait = 0;
                        pend = '{16'h0D02, 16'h1053, 16'h1150, 16'h1460};
                        issue_next = 1;
                    end
                end
                if (issue_next) begin
                    issue_next  = 0;
                    e_wrt       = 1'b1;
                    e_cmd       = pend.pop_front();
                    outstanding = 1;
                end
                if (vld_next) begin
                    vld_next = 0;
                    e_vld    = 1'b1;
                    e_ptch   = {bmap[7'h23], bmap[7'h22]};
                    e_az     = {bmap[7'h2D], bmap[7'h2C]};
                end
            end
            chk("wrt", spi_if.wrt, e_wrt);
            chk("cmd", spi_if.cmd, e_cmd);
            chk("vld", vld, e_vld);
            chk("ptch_rt", ptch_rt, e_ptch);
            chk("AZ", AZ, e_az);
            if (vld) vld_seen++;
            // inputs now present are the ones the DUT samples at the next edge
            if (rst_n) begin
                idle = !in_wait && !outstanding && (pend.size() == 0) && !issue_next && !e_vld;
                if (outstanding && spi_if.done) begin
                    outstanding = 0;
                    if (e_cmd[15]) bmap[e_cmd[14:8]] = spi_if.inert_data[7:0];
                    if (pend.size() > 0) issue_next = 1;
                    else if (e_cmd[15]) vld_next = 1;
                end else if (idle && prev_int) begin
                    pend = '{16'hA200, 16'hA300, 16'hAC00, 16'hAD00};
                    issue_next = 1;
                end
                prev_int = INT;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_log(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (rlog.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(name, rlog.size() >= n, 1);
    endtask

    task automatic wait_vld(input int target, input int budget);
        int k;
        k = 0;
        while (vld_seen < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("vld_timeout", vld_seen >= target, 1);
    endtask

    task automatic first_wrt(input string name);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!spi_if.wrt && n < INIT_CYC + 20);
        chk({name, "_latency"}, n, INIT_CYC);
        chk({name, "_cmd"}, spi_if.cmd, 16'h0D02);
    endtask

    task automatic check_init(input int base);
        logic [15:0] iw [4];
        iw = '{16'h0D02, 16'h1053, 16'h1150, 16'h1460};
        wait_log(base + 4, 400, "init_timeout");
        for (int i = 0; i < 4; i++) chk("init_cmd", rlog[base + i], iw[i]);
        repeat (50) @(negedge clk);
    endtask

    task automatic run_seq(input logic [7:0] b0, b1, b2, b3, input int w, input bit noise);
        int          base, v0;
        logic [15:0] rw [4];
        rw = '{16'hA200, 16'hA300, 16'hAC00, 16'hAD00};
        resp_byte = '{b0, b1, b2, b3};
        base = rlog.size();
        v0   = vld_seen;
        @(negedge clk);
        INT = 1'b1;
        repeat (w) @(negedge clk);
        INT = 1'b0;
        if (noise) begin
            wait_log(base + 2, 200, "rd1_timeout");
            repeat (5) @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                INT = 1'b1;
                repeat ($urandom_range(1, 4)) @(negedge clk);
                INT = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end
        wait_vld(v0 + 1, 400);
        chk("seq_ptch", ptch_rt, {b1, b0});
        chk("seq_az", AZ, {b3, b2});
        repeat (10) @(negedge clk);
        chk("vld_once", vld_seen, v0 + 1);
        chk("rd_count", rlog.size(), base + 4);
        for (int i = 0; i < 4; i++) chk("rd_cmd", rlog[base + i], rw[i]);
    endtask

    // ---------------- main stimulus ----------------
    initial begin : main
        int base, v0;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_wrt", spi_if.wrt, 0);
        chk("rst_cmd", spi_if.cmd, 16'h0000);
        chk("rst_vld", vld, 0);
        chk("rst_ptch", ptch_rt, 16'h0000);
        chk("rst_az", AZ, 16'h0000);

        @(negedge clk);
        rst_n = 1'b1;
        first_wrt("first_wrt");
        check_init(0);

        // pinned read values
        run_seq(8'h34, 8'h12, 8'hF0, 8'h3F, 2, 1'b0);
        chk("pin_ptch", ptch_rt, 16'h1234);
        chk("pin_az", AZ, 16'h3FF0);

        // INT noise during the second read
        run_seq(8'h9A, 8'h78, 8'h01, 8'h80, 1, 1'b1);

        for (int s = 0; s < 5; s++) begin
            run_seq(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                    8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                    $urandom_range(1, 5), 1'($urandom_range(0, 1)));
        end

        // spurious done while idle
        base = rlog.size();
        v0   = vld_seen;
        @(negedge clk);
        spur_req = 1'b1;
        repeat (20) @(negedge clk);
        chk("spur_no_wrt", rlog.size(), base);
        chk("spur_no_vld", vld_seen, v0);

        // reset during the third read
        resp_byte = '{8'h11, 8'h22, 8'h33, 8'h44};
        base = rlog.size();
        @(negedge clk);
        INT = 1'b1;
        @(negedge clk);
        INT = 1'b0;
        wait_log(base + 3, 200, "rd2_timeout");
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wrt", spi_if.wrt, 0);
        chk("mid_rst_cmd", spi_if.cmd, 16'h0000);
        chk("mid_rst_vld", vld, 0);
        chk("mid_rst_ptch", ptch_rt, 16'h0000);
        chk("mid_rst_az", AZ, 16'h0000);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        base = rlog.size();
        v0   = vld_seen;
`ifdef FAST_SIM_EN
        first_wrt("reinit_wrt");
        check_init(base);
        run_seq(8'hA5, 8'h5A, 8'hC3, 8'h3C, 3, 1'b0);
`else
        for (int i = 0; i < 10; i++) begin
            INT = 1'b1;
            repeat ($urandom_range(2, 20)) @(negedge clk);
            INT = 1'b0;
            repeat ($urandom_range(50, 80)) @(negedge clk);
        end
        chk("reinit_no_read", rlog.size(), base);
        chk("reinit_no_vld", vld_seen, v0);
`endif
        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/inert_intf.md
INERT_INTF -- requirements
Module: inert_intf

Interface
REQ-001 SHALL have parameter PTCH_ADDR, default 7'h22, meaning pitch-rate low-byte register address (high byte at PTCH_ADDR+1).
REQ-002 SHALL have parameter AZ_ADDR, default 7'h2C, meaning Z-accel low-byte register address (high byte at AZ_ADDR+1).
REQ-003 SHALL have port clk, input, 1, system clock; all flops on rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port INT, input, 1, sensor data-ready, asynchronous to clk.
REQ-006 SHALL have port wrt, output, 1, one-cycle request to the SPI monarch.
REQ-007 SHALL have port cmd, output, 16, SPI word to send: {R/W, addr[6:0], data[7:0]}.
REQ-008 SHALL have port done, input, 1, one-cycle SPI transaction complete.
REQ-009 SHALL have port inert_data, input, 16, SPI read word; only [7:0] used.
REQ-010 SHALL have port ptch_rt, output, 16, signed pitch rate.
REQ-011 SHALL have port AZ, output, 16, signed Z acceleration.
REQ-012 SHALL have port vld, output, 1, one-cycle pulse: new ptch_rt/AZ pair.

Function
REQ-013 INT SHALL pass through a 2-flop synchronizer; only the second-stage flop output is used.
REQ-014 States SHALL be: INIT_WAIT, INIT_WR (index 0..3), WAIT_INT, READ (index 0..3), SHOW.
REQ-015 INIT_WAIT: 16-bit timer counts from 0; on all-ones, go to INIT_WR index 0.
REQ-016 INIT_WR words in order: 16'h0D02, 16'h1053, 16'h1150, 16'h1460.
REQ-017 Each transaction: wrt high exactly one cycle on state entry; cmd stable from that cycle until done.
REQ-018 Next transaction's wrt SHALL assert in the cycle after done (1-cycle gap).
REQ-019 done after INIT_WR index 3 SHALL go to WAIT_INT.
REQ-020 WAIT_INT: synchronized INT high SHALL start READ index 0; otherwise hold.
REQ-021 READ cmds in order: {1'b1,PTCH_ADDR,8'h00}, {1'b1,PTCH_ADDR+1,8'h00}, {1'b1,AZ_ADDR,8'h00}, {1'b1,AZ_ADDR+1,8'h00}; defaults give 16'hA200, A300, AC00, AD00.
REQ-022 On each READ done, inert_data[7:0] SHALL be captured into that index's holding byte.
REQ-023 After done of READ index 3, SHOW for one cycle: ptch_rt={PH,PL}, AZ={AH,AL} update and vld=1, then WAIT_INT.
REQ-024 ptch_rt and AZ SHALL change only in the vld cycle; vld is never high two consecutive cycles.
REQ-025 INT activity outside WAIT_INT SHALL be ignored; no queuing.
REQ-026 done while no transaction is pending SHALL be ignored.
REQ-027 wrt SHALL never assert while a transaction is pending.

Reset
REQ-028 rst_n low SHALL force INIT_WAIT, timer=0, wrt=0, cmd=16'h0000, vld=0, ptch_rt=0, AZ=0, holding bytes=0, sync flops=0.
REQ-029 Reset mid-transaction SHALL abandon it; after release the full init sequence repeats.

Configuration
REQ-030 Macro FAST_SIM_EN defined: INIT_WAIT timer is 9 bits (exit after 512 cycles); undefined: 16 bits (65536 cycles).

Structure
REQ-031 Shared package SHALL hold the state enum, the four init words, and the SPI read-bit constant.
REQ-032 Sub-module int_sync (2-flop synchronizer) is natural; everything else stays in inert_intf.

Verification
REQ-033 Reset release, FAST_SIM_EN defined -> first wrt 512 cycles later with cmd=16'h0D02.
REQ-034 SPI model returns done 40 cycles after each wrt -> cmds 0D02,1053,1150,1460 in order, each wrt one cycle after prior done.
REQ-035 INT high after init, reads return 8'h34,8'h12,8'hF0,8'h3F -> single vld pulse, ptch_rt=16'h1234, AZ=16'h3FF0.
REQ-036 INT toggled during READ index 1 -> no extra transaction; exactly one vld per sequence.
REQ-037 rst_n low during READ index 2 -> outputs zero immediately; after release, init words resent before any read.
REQ-038 Spurious done in WAIT_INT -> no state change, no wrt, no vld.
